booth_dot_accumulator: RTL and testbench
========================================

// Module: booth_dot_accumulator
// PURPOSE
//  Downstream consumer of the 4-bit radix-4 Booth multiplier.
//  - Accepts the stream of signed products over a valid/ready handshake.
//  - Sums the terms of one dot-product vector; the vector end is marked by prod_last.
//  - Presents the saturated sum on a valid/ready output port and holds it until it is taken.
//  - Sits between the multiplier array and the result writeback logic.
// PARAMETERS
//  PROD_W  8   product width; two's complement; the multiplier produces 8 bits
//  ACC_W   16  accumulator width; two's complement; must be > PROD_W
//  CNT_W   8   width of the term counter
// PORTS
//  clk         in   1       single clock, rising edge
//  rst_n       in   1       asynchronous assert, active-low reset
//  clr         in   1       synchronous abort of the vector currently being accumulated
//  prod_valid  in   1       product is valid this cycle
//  prod_ready  out  1       block accepts the product this cycle
//  product     in   PROD_W  signed product from the Booth multiplier
//  prod_last   in   1       qualifies product: this is the final term of the vector
//  acc_valid   out  1       result is valid
//  acc_ready   in   1       downstream takes the result
//  acc_out     out  ACC_W   signed saturated sum
//  acc_count   out  CNT_W   number of terms accepted; saturates at 2^CNT_W-1
//  acc_sat     out  1       sticky flag: saturation occurred in this vector
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=ACCUM; acc_out=0; acc_count=0; acc_sat=0; acc_valid=0.
//   - prod_ready is 0 while rst_n is low.
//  Handshakes:
//   - A product is accepted when prod_valid && prod_ready.
//   - A result is taken when acc_valid && acc_ready.
//   - The product side does not depend combinationally on prod_valid.
//   - acc_out, acc_count and acc_sat are stable while acc_valid=1 and acc_ready=0.
//  FSM states ACCUM and HOLD:
//   ACCUM:
//    - prod_ready=1; acc_valid=0.
//    - On accept: acc <= sat(acc + sext(product)); count <= count+1 (saturating); sat |= overflow.
//    - If the accepted product has prod_last=1, go to HOLD.
//    - Latency: acc_valid rises the cycle after the last term is accepted.
//   HOLD:
//    - acc_valid=1; prod_ready=acc_ready (drain and new-vector start overlap).
//    - On acc_ready with no accept: acc=0, count=0, sat=0, go to ACCUM.
//    - On acc_ready with a simultaneous accept: acc <= sext(product), count <= 1, sat <= 0.
//      The next state is HOLD if prod_last=1, otherwise ACCUM.
//  Arithmetic:
//   - The sum is computed at ACC_W+1 bits.
//   - On overflow it clamps to 2^(ACC_W-1)-1; on underflow to -2^(ACC_W-1). acc_sat is set.
//  clr:
//   - In ACCUM, clr zeroes acc, count and sat and has priority over a same-cycle accept.
//     The product is still consumed and discarded.
//   - In HOLD, clr is ignored; a completed result is never lost.
//  Mid-operation reset: all state is cleared immediately; any partial vector is discarded.
//  A prod_last=1 on the first term is legal: a one-term vector, acc_count=1.
// STRUCTURE
//  - booth_pkg: state encoding (ACCUM, HOLD) and ACC_MAX/ACC_MIN localparams derived from ACC_W.
//  - Sub-module booth_sat_add (signed a + sext(b), clamped result, ovf flag), combinational.
//  - Remaining logic: one FSM and the acc, count and sat registers in this module.
// TESTING
//  1. Feed 3,-5,7(last), acc_ready=1 -> acc_valid one cycle after last; acc_out=5, acc_count=3, acc_sat=0.
//  2. Feed 64 x512 (last on 512th) -> acc_out=32767, acc_sat=1, acc_count=255.
//  3. Feed -64 x513 (last) -> acc_out=-32768, acc_sat=1.
//  4. Result held with acc_ready=0 for 10 cycles -> prod_ready=0, outputs unchanged.
//     Then acc_ready=1 with product=9 -> result taken; new vector starts with acc=9.
//  5. Feed 4,4, then clr with 6 in the same cycle, then 2(last) -> acc_out=2, acc_count=1.
//  6. rst_n low after 2 of 4 terms -> outputs zero asynchronously.
//     After release, feed 1(last) -> acc_out=1, acc_count=1.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared definitions for the Booth dot-product accumulator: default widths,
// FSM state encoding and the saturation bounds of the default accumulator.
package booth_pkg;

  localparam int PROD_W_DEF = 8;
  localparam int ACC_W_DEF  = 16;
  localparam int CNT_W_DEF  = 8;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_e;

  localparam logic signed [ACC_W_DEF-1:0] ACC_MAX = {1'b0, {(ACC_W_DEF-1){1'b1}}};
  localparam logic signed [ACC_W_DEF-1:0] ACC_MIN = {1'b1, {(ACC_W_DEF-1){1'b0}}};

endpackage

// File: rtl/booth_sat_add.sv
// Combinational signed add of a wide accumulator and a sign-extended narrow
// operand, clamped to the accumulator range with an overflow indication.
module booth_sat_add #(
  parameter int A_W = 16,
  parameter int B_W = 8
) (
  input  logic signed [A_W-1:0] a,
  input  logic signed [B_W-1:0] b,
  output logic signed [A_W-1:0] sum,
  output logic                  ovf
);

  localparam logic signed [A_W-1:0] SAT_MAX = {1'b0, {(A_W-1){1'b1}}};
  localparam logic signed [A_W-1:0] SAT_MIN = {1'b1, {(A_W-1){1'b0}}};

  logic signed [A_W:0] wide;

  // One guard bit is enough: the two top bits disagree exactly on overflow.
  assign wide = {a[A_W-1], a} + {{(A_W+1-B_W){b[B_W-1]}}, b};
  assign ovf  = wide[A_W] ^ wide[A_W-1];

  always_comb begin
    sum = wide[A_W-1:0];
    if (ovf) begin
      sum = wide[A_W] ? SAT_MIN : SAT_MAX;
    end
  end

endmodule

// File: rtl/booth_dot_accumulator.sv
// Accumulates a stream of signed Booth products into a saturated dot-product
// sum and hands each completed vector downstream over a valid/ready port.
module booth_dot_accumulator
  import booth_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     prod_valid,
  output logic                     prod_ready,
  input  logic signed [PROD_W-1:0] product,
  input  logic                     prod_last,
  output logic                     acc_valid,
  input  logic                     acc_ready,
  output logic signed [ACC_W-1:0]  acc_out,
  output logic [CNT_W-1:0]         acc_count,
  output logic                     acc_sat
);

  acc_state_e              state_reg;
  logic signed [ACC_W-1:0] acc_reg;
  logic [CNT_W-1:0]        count_reg;
  logic                    sat_reg;

  logic signed [ACC_W-1:0] sum_next;
  logic                    sum_ovf;
  logic [CNT_W-1:0]        count_inc;
  logic signed [ACC_W-1:0] product_sext;
  logic                    accept;

  booth_sat_add #(
    .A_W (ACC_W),
    .B_W (PROD_W)
  ) u_sat_add (
    .a   (acc_reg),
    .b   (product),
    .sum (sum_next),
    .ovf (sum_ovf)
  );

  assign count_inc    = (count_reg == {CNT_W{1'b1}}) ? count_reg : count_reg + CNT_W'(1);
  assign product_sext = {{(ACC_W-PROD_W){product[PROD_W-1]}}, product};

  // In HOLD a new vector may only start on the cycle the result drains.
  assign prod_ready = rst_n && ((state_reg == ACCUM) || acc_ready);
  assign accept     = prod_valid && prod_ready;

  assign acc_valid = (state_reg == HOLD);
  assign acc_out   = acc_reg;
  assign acc_count = count_reg;
  assign acc_sat   = sat_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ACCUM;
      acc_reg   <= '0;
      count_reg <= '0;
      sat_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ACCUM: begin
          if (clr) begin
            acc_reg   <= '0;
            count_reg <= '0;
            sat_reg   <= 1'b0;
          end else if (accept) begin
            acc_reg   <= sum_next;
            count_reg <= count_inc;
            sat_reg   <= sat_reg | sum_ovf;
            if (prod_last) begin
              state_reg <= HOLD;
            end
          end
        end
        HOLD: begin
          if (acc_ready) begin
            if (accept) begin
              acc_reg   <= product_sext;
              count_reg <= CNT_W'(1);
              sat_reg   <= 1'b0;
              state_reg <= prod_last ? HOLD : ACCUM;
            end else begin
              acc_reg   <= '0;
              count_reg <= '0;
              sat_reg   <= 1'b0;
              state_reg <= ACCUM;
            end
          end
        end
        default: state_reg <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_dot_accumulator.sv
// Scoreboard bench: the stimulus side feeds products, a reference model
// queues the expected vector results, and a monitor compares each drained one.
module tb_booth_dot_accumulator;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               clr;
  logic               prod_valid;
  logic               prod_ready;
  logic signed [7:0]  product;
  logic               prod_last;
  logic               acc_valid;
  logic               acc_ready;
  logic signed [15:0] acc_out;
  logic [7:0]         acc_count;
  logic               acc_sat;

  booth_dot_accumulator #(.PROD_W(8), .ACC_W(16), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .product    (product),
    .prod_last  (prod_last),
    .acc_valid  (acc_valid),
    .acc_ready  (acc_ready),
    .acc_out    (acc_out),
    .acc_count  (acc_count),
    .acc_sat    (acc_sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    int acc;
    int cnt;
    bit sat;
  } result_t;

  result_t exp_q[$];
  int      checks = 0;
  int      passes = 0;
  bit      rand_mode = 1'b0;

  // reference model of the vector being summed
  int run_sum = 0;
  int run_cnt = 0;
  bit run_sat = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic model_clear();
    run_sum = 0;
    run_cnt = 0;
    run_sat = 1'b0;
  endtask

  task automatic model_add(input int p);
    int s;
    s = run_sum + p;
    if (s > 32767) begin
      s = 32767;
      run_sat = 1'b1;
    end else if (s < -32768) begin
      s = -32768;
      run_sat = 1'b1;
    end
    run_sum = s;
    if (run_cnt < 255) run_cnt++;
  endtask

  // Monitor + model update; inputs are driven at posedge+1, so values seen
  // at the negedge are the ones the next rising edge acts upon.
  bit      chk_latency = 1'b0;
  bit      have_prev = 1'b0;
  result_t prev;

  always @(negedge clk) begin
    if (!rst_n) begin
      model_clear();
      chk_latency = 1'b0;
      have_prev = 1'b0;
    end else begin
      if (chk_latency) check("latency_valid", acc_valid, 1);
      chk_latency = 1'b0;
      if (have_prev) begin
        check("hold_valid", acc_valid, 1);
        check("hold_acc", acc_out, prev.acc);
        check("hold_cnt", acc_count, prev.cnt);
        check("hold_sat", acc_sat, prev.sat);
      end
      have_prev = acc_valid && !acc_ready;
      prev.acc = acc_out;
      prev.cnt = acc_count;
      prev.sat = acc_sat;
      if (acc_valid && acc_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          result_t e;
          e = exp_q.pop_front();
          check("result_acc", acc_out, e.acc);
          check("result_cnt", acc_count, e.cnt);
          check("result_sat", acc_sat, e.sat);
        end
      end
      if (clr && !acc_valid) begin
        model_clear();
      end else if (prod_valid && prod_ready) begin
        model_add(int'(product));
        if (prod_last) begin
          result_t r;
          r.acc = run_sum;
          r.cnt = run_cnt;
          r.sat = run_sat;
          exp_q.push_back(r);
          model_clear();
          chk_latency = 1'b1;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_mode) acc_ready = ($urandom_range(0, 3) != 0);
  end

  // Caller is at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input int p, input bit l, input bit c);
    int n;
    prod_valid = 1'b1;
    product = 8'(p);
    prod_last = l;
    clr = c;
    n = 0;
    @(negedge clk);
    while (!prod_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!prod_ready) begin
      checks++;
      $display("FAIL send_timeout: prod_ready=0 expected 1 within 100 cycles");
    end
    @(posedge clk);
    #1;
    prod_valid = 1'b0;
    prod_last = 1'b0;
    clr = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    clr = 1'b0;
    prod_valid = 1'b0;
    product = '0;
    prod_last = 1'b0;
    acc_ready = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_acc", acc_out, 0);
    check("reset_cnt", acc_count, 0);
    check("reset_sat", acc_sat, 0);
    check("reset_valid", acc_valid, 0);
    check("reset_ready", prod_ready, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle();

    // three-term vector
    acc_ready = 1'b1;
    send(3, 0, 0);
    send(-5, 0, 0);
    send(7, 1, 0);
    check("t1_valid", acc_valid, 1);
    check("t1_acc", acc_out, 5);
    check("t1_cnt", acc_count, 3);
    check("t1_sat", acc_sat, 0);
    idle();

    // positive saturation, count saturation
    for (int i = 0; i < 512; i++) send(64, (i == 511), 0);
    check("t2_acc", acc_out, 32767);
    check("t2_cnt", acc_count, 255);
    check("t2_sat", acc_sat, 1);
    idle();

    // negative saturation
    for (int i = 0; i < 513; i++) send(-64, (i == 512), 0);
    check("t3_acc", acc_out, -32768);
    check("t3_sat", acc_sat, 1);
    idle();

    // result held while downstream stalls
    acc_ready = 1'b0;
    send(1, 0, 0);
    send(2, 1, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t4_stall_ready", prod_ready, 0);
      check("t4_stall_acc", acc_out, 3);
    end
    idle();
    acc_ready = 1'b1;
    send(9, 0, 0);
    check("t4_new_acc", acc_out, 9);
    check("t4_new_valid", acc_valid, 0);
    check("t4_new_cnt", acc_count, 1);
    send(1, 1, 0);
    idle();

    // clr beats a same-cycle product
    send(4, 0, 0);
    send(4, 0, 0);
    send(6, 0, 1);
    send(2, 1, 0);
    check("t5_acc", acc_out, 2);
    check("t5_cnt", acc_count, 1);
    idle();

    // mid-vector asynchronous reset
    send(1, 0, 0);
    send(2, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    check("t6_rst_acc", acc_out, 0);
    check("t6_rst_cnt", acc_count, 0);
    check("t6_rst_ready", prod_ready, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle();
    send(1, 1, 0);
    check("t6_acc", acc_out, 1);
    check("t6_cnt", acc_count, 1);
    idle();

    // randomized vectors with random backpressure, gaps and clears
    rand_mode = 1'b1;
    for (int v = 0; v < 40; v++) begin
      int len;
      bit big;
      big = ($urandom_range(0, 7) == 0);
      len = big ? $urandom_range(260, 300) : $urandom_range(1, 12);
      for (int t = 0; t < len; t++) begin
        int p;
        p = big ? ($urandom_range(0, 1) ? 127 : -128) : $urandom_range(0, 255) - 128;
        repeat ($urandom_range(0, 2)) idle();
        if ($urandom_range(0, 31) == 0) begin
          clr = 1'b1;
          idle();
          clr = 1'b0;
        end
        send(p, (t == len - 1), ($urandom_range(0, 15) == 0));
      end
    end

    rand_mode = 1'b0;
    acc_ready = 1'b1;
    for (int n = 0; n < 100 && exp_q.size() != 0; n++) idle();
    repeat (3) idle();
    check("drain_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
